// File: rtl/secure_frv_masked_addsub.sv
// Masked Boolean-share adder/subtractor (Kogge-Stone carry network).
// Every nonlinear step goes through an external masked AND unit.
module secure_frv_masked_addsub #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic                 start,
  input  logic                 i_sub,
  input  logic [BIT_WIDTH-1:0] i_a0,
  input  logic [BIT_WIDTH-1:0] i_a1,
  input  logic [BIT_WIDTH-1:0] i_b0,
  input  logic [BIT_WIDTH-1:0] i_b1,
  output logic                 busy,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] o_sum0,
  output logic [BIT_WIDTH-1:0] o_sum1,
  output logic                 and_ena,
  output logic [BIT_WIDTH-1:0] and_x0,
  output logic [BIT_WIDTH-1:0] and_x1,
  output logic [BIT_WIDTH-1:0] and_y0,
  output logic [BIT_WIDTH-1:0] and_y1,
  input  logic [BIT_WIDTH-1:0] and_q0,
  input  logic [BIT_WIDTH-1:0] and_q1,
  input  logic                 and_rdy
);

  localparam int LOG = $clog2(BIT_WIDTH);
  localparam int DW  = (LOG > 1) ? $clog2(LOG) : 1;

  typedef logic [BIT_WIDTH-1:0] word_t;
  typedef logic [DW-1:0]        dist_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RND_G,
    S_RND_P,
    S_FINAL,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  dist_t  d_q, d_d;
  logic   sub_q, sub_d;
  word_t  p0_q, p0_d, p1_q, p1_d;
  word_t  pi0_q, pi0_d, pi1_q, pi1_d;
  word_t  g0_q, g0_d, g1_q, g1_d;
  word_t  x0_q, x0_d, x1_q, x1_d;
  word_t  y0_q, y0_d, y1_q, y1_d;
  word_t  s0_q, s0_d, s1_q, s1_d;

  word_t  bb0;
  word_t  gi0, gi1;
  word_t  gn0, gn1;
  dist_t  d_inc;

  // Per-share left shift by 2^k with zero fill.
  function automatic word_t shl(input word_t v, input dist_t k);
    shl = v << (32'd1 << k);
  endfunction

  // State and share registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      sub_q   <= 1'b0;
      p0_q    <= '0;
      p1_q    <= '0;
      pi0_q   <= '0;
      pi1_q   <= '0;
      g0_q    <= '0;
      g1_q    <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      sub_q   <= sub_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      pi0_q   <= pi0_d;
      pi1_q   <= pi1_d;
      g0_q    <= g0_d;
      g1_q    <= g1_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
    end
  end

  // Next-state and share datapath; AND operands are loaded one
  // cycle ahead so they are stable for the whole request.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    sub_d   = sub_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    pi0_d   = pi0_q;
    pi1_d   = pi1_q;
    g0_d    = g0_q;
    g1_d    = g1_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    s0_d    = s0_q;
    s1_d    = s1_q;

    bb0   = i_sub ? ~i_b0 : i_b0;
    gi0   = and_q0 ^ word_t'(sub_q & p0_q[0]);
    gi1   = and_q1 ^ word_t'(sub_q & p1_q[0]);
    gn0   = g0_q ^ and_q0;
    gn1   = g1_q ^ and_q1;
    d_inc = d_q + dist_t'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sub_d   = i_sub;
          p0_d    = i_a0 ^ bb0;
          p1_d    = i_a1 ^ i_b1;
          pi0_d   = i_a0 ^ bb0;
          pi1_d   = i_a1 ^ i_b1;
          g0_d    = '0;
          g1_d    = '0;
          d_d     = '0;
          x0_d    = i_a0;
          x1_d    = i_a1;
          y0_d    = bb0;
          y1_d    = i_b1;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        if (and_rdy) begin
          g0_d    = gi0;
          g1_d    = gi1;
          d_d     = '0;
          x0_d    = p0_q;
          x1_d    = p1_q;
          y0_d    = gi0 << 1;
          y1_d    = gi1 << 1;
          state_d = S_RND_G;
        end
      end
      S_RND_G: begin
        if (and_rdy) begin
          g0_d = gn0;
          g1_d = gn1;
          if (d_q == dist_t'(LOG - 1)) begin
            x0_d    = '0;
            x1_d    = '0;
            y0_d    = '0;
            y1_d    = '0;
            state_d = S_FINAL;
          end else begin
            x0_d    = p0_q;
            x1_d    = p1_q;
            y0_d    = shl(p0_q, d_q);
            y1_d    = shl(p1_q, d_q);
            state_d = S_RND_P;
          end
        end
      end
      S_RND_P: begin
        if (and_rdy) begin
          p0_d    = and_q0;
          p1_d    = and_q1;
          d_d     = d_inc;
          x0_d    = and_q0;
          x1_d    = and_q1;
          y0_d    = shl(g0_q, d_inc);
          y1_d    = shl(g1_q, d_inc);
          state_d = S_RND_G;
        end
      end
      S_FINAL: begin
        s0_d    = pi0_q ^ (g0_q << 1) ^ word_t'(sub_q);
        s1_d    = pi1_q ^ (g1_q << 1);
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign and_ena = (state_q == S_INIT)
                 | (state_q == S_RND_G)
                 | (state_q == S_RND_P);
  assign and_x0  = x0_q;
  assign and_x1  = x1_q;
  assign and_y0  = y0_q;
  assign and_y1  = y1_q;
  assign o_sum0  = s0_q;
  assign o_sum1  = s1_q;

endmodule

// File: doc/secure_frv_masked_addsub.md
SECURE_FRV_MASKED_ADDSUB -- requirements
Module: secure_frv_masked_addsub

Interface
REQ-001 Parameter BIT_WIDTH, default 32, operand width; SHALL be a power of two and at least 2; LOG = log2(BIT_WIDTH).
REQ-002 g_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 g_resetn  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request strobe; sampled only in IDLE.
REQ-005 i_sub  in  1  0 = add, 1 = subtract (a - b); captured with start.
REQ-006 i_a0, i_a1, i_b0, i_b1  in  BIT_WIDTH each  Boolean shares of a and b; captured with start.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 done  out  1  one-cycle pulse; o_sum shares valid while high and held until the next accepted start.
REQ-009 o_sum0, o_sum1  out  BIT_WIDTH each  Boolean shares of (a +/- b) mod 2^BIT_WIDTH.
REQ-010 and_ena  out  1  request to the external masked AND unit (masked bitwise unit's AND path).
REQ-011 and_x0, and_x1, and_y0, and_y1  out  BIT_WIDTH each  AND operand shares.
REQ-012 and_q0, and_q1  in  BIT_WIDTH each  AND result shares; valid when and_rdy is high.
REQ-013 and_rdy  in  1  AND result valid; latency L >= 1 cycles after and_ena rises, unknown to this block.

Function
REQ-014 Shares SHALL never be combined across share index; all linear steps (XOR, shift, invert) SHALL be applied per share; every nonlinear step SHALL go through the AND port.
REQ-015 Capture: p0 = a0 ^ b0', p1 = a1 ^ b1', where b0' = ~b0 if i_sub else b0 and b1' = b1; p_init is kept for the final XOR.
REQ-016 FSM states: IDLE, INIT, RND_G, RND_P, FINAL, DONE.
REQ-017 IDLE: start = 1 -> capture operands, go to INIT. start in any other state SHALL be ignored.
REQ-018 INIT: issue g = a & b'; on and_rdy -> set g; if i_sub, then g[0] ^= p[0] per share (carry-in = 1); set d = 0; go to RND_G.
REQ-019 RND_G: issue p & (g << 2^d), with per-share shift and zero fill; on and_rdy -> g ^= result per share.
    - If d = LOG-1, go to FINAL.
    - Otherwise go to RND_P.
REQ-020 RND_P: issue p & (p << 2^d); on and_rdy -> p = result, d = d + 1, go to RND_G.
REQ-021 AND handshake:
    - and_ena SHALL be high in INIT, RND_G and RND_P and low elsewhere.
    - Operands SHALL be registered and held stable while and_ena is high.
    - The result SHALL be captured on the edge where and_rdy = 1, and the next operation SHALL follow the next cycle with and_ena staying high.
    - and_rdy outside INIT/RND_G/RND_P SHALL be ignored.
REQ-022 Total AND operations per request = 2*LOG (10 for BIT_WIDTH = 32).
REQ-023 FINAL: o_sumK <= p_initK ^ {gK[BIT_WIDTH-2:0], 0} per share; if i_sub, o_sum0 bit 0 SHALL additionally be inverted (carry-in); go to DONE.
REQ-024 DONE: done = 1 for exactly one cycle; go to IDLE; start SHALL be accepted from the following cycle.
REQ-025 Latency: with fixed AND latency L, done SHALL be high exactly 2 + 2*LOG*L cycles after the start cycle (22 for BIT_WIDTH = 32, L = 2).
REQ-026 Carry-out SHALL be discarded; the result wraps mod 2^BIT_WIDTH.

Reset
REQ-027 While g_resetn = 0, immediately and regardless of clock:
    - state = IDLE, d = 0.
    - busy, done and and_ena = 0.
    - o_sum0, o_sum1, all and_* operand outputs and all internal share registers = 0.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no done pulse; a start accepted after release SHALL compute correctly.

Verification
REQ-029 The bench SHALL use a behavioural AND responder (q = x & y recombined, re-shared with a random mask) with configurable latency L, and random masks on inputs; results SHALL be checked as o_sum0 ^ o_sum1.
REQ-030 Add, L = 2: a = 5, b = 7, a0 = 0x12345678 -> done in cycle 22 after start; sum = 0x0000000C; 10 and_rdy handshakes observed.
REQ-031 Sub: a = 5, b = 7, i_sub = 1 -> 0xFFFFFFFE; a = 0x80000000, b = 1 -> 0x7FFFFFFF.
REQ-032 Wrap: a = 0xFFFFFFFF, b = 1, add -> 0x00000000; a = 0, b = 0, sub -> 0x00000000.
REQ-033 Ignored start and variable latency: start pulsed while busy -> no effect; L randomised 1..5 per operation -> result correct, and operands stable while and_ena is high.
REQ-034 Reset mid-operation: g_resetn low during RND_P -> all outputs 0 at once; no done pulse; next request a = 3, b = 4 -> 7.
